// File: rtl/lag_sensor_capture_pkg.sv
// rtl/lag_sensor_capture_pkg.sv - shared state enum and default constants for the lag sensor capture
package lag_sensor_capture_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DARK = 2'd1,
    MEASURE   = 2'd2,
    RELEASE   = 2'd3
  } lag_state_t;

  // Defaults shared with the lag/result formatter
  localparam int                            DEFAULT_LAG_COUNTER_SIZE = 24;
  localparam int                            DEFAULT_DEBOUNCE         = 16;
  localparam logic [DEFAULT_LAG_COUNTER_SIZE-1:0] DEFAULT_TIMEOUT    = 24'hFF_FFFF;

endpackage

// File: rtl/lag_sensor_capture_sensor_sync.sv
// rtl/lag_sensor_capture_sensor_sync.sv - N-stage synchronizer with registered rising-edge pulse
module lag_sensor_capture_sensor_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_sensor,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rise;

  // Shift the asynchronous input through the chain; the pulse lines up with the level going high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sensor};
      r_rise <= r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_rise;

endmodule

// File: rtl/lag_sensor_capture.sv
// rtl/lag_sensor_capture.sv - display lag measurement FSM; LAG_AVERAGE_EN adds an 8-result running average
module lag_sensor_capture
  import lag_sensor_capture_pkg::*;
#(
  parameter int                          SYNC_STAGES      = 2,
  parameter int                          DEBOUNCE         = DEFAULT_DEBOUNCE,
  parameter int                          LAG_COUNTER_SIZE = DEFAULT_LAG_COUNTER_SIZE,
  parameter logic [LAG_COUNTER_SIZE-1:0] TIMEOUT          = DEFAULT_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        starttrigger,
  input  logic                        sensor,
  output logic [LAG_COUNTER_SIZE-1:0] lag_cycles,
  output logic                        lag_valid,
  output logic                        timeout,
  output logic                        overrun,
  output logic                        busy
`ifdef LAG_AVERAGE_EN
  ,
  output logic [LAG_COUNTER_SIZE-1:0] lag_avg
`endif
);

  localparam logic [LAG_COUNTER_SIZE-1:0] CNT_ONE = LAG_COUNTER_SIZE'(1);
  localparam logic [7:0]                  DEB     = 8'(DEBOUNCE);
  localparam logic [7:0]                  DEB_ONE = 8'd1;

  lag_state_t                  r_state, w_state_nxt;
  logic [LAG_COUNTER_SIZE-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]                  r_dbc, w_dbc_nxt;
  logic [LAG_COUNTER_SIZE-1:0] r_cand, w_cand_nxt;
  logic [LAG_COUNTER_SIZE-1:0] r_lag_cycles, w_lag_nxt;
  logic                        r_lag_valid, w_valid_nxt;
  logic                        r_timeout, w_timeout_nxt;
  logic                        r_overrun, w_overrun_nxt;
  logic                        r_busy, w_busy_nxt;
  logic                        w_level, w_rise;

  lag_sensor_capture_sensor_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_sensor(sensor),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // Register FSM state, counters and published results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dbc        <= '0;
      r_cand       <= '0;
      r_lag_cycles <= '0;
      r_lag_valid  <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dbc        <= w_dbc_nxt;
      r_cand       <= w_cand_nxt;
      r_lag_cycles <= w_lag_nxt;
      r_lag_valid  <= w_valid_nxt;
      r_timeout    <= w_timeout_nxt;
      r_overrun    <= w_overrun_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state and next-value logic; the counter saturates at TIMEOUT instead of wrapping
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_inc     = (r_cnt == TIMEOUT) ? TIMEOUT : r_cnt + CNT_ONE;
    w_cnt_nxt     = r_cnt;
    w_dbc_nxt     = r_dbc;
    w_cand_nxt    = r_cand;
    w_lag_nxt     = r_lag_cycles;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
    w_overrun_nxt = r_overrun | (starttrigger && (r_state != IDLE));
    case (r_state)
      IDLE: begin
        if (starttrigger) begin
          w_cnt_nxt   = '0;
          w_dbc_nxt   = '0;
          w_state_nxt = w_level ? WAIT_DARK : MEASURE;
        end
      end
      WAIT_DARK: begin
        // Count keeps running so the result stays referenced to the trigger
        w_cnt_nxt = w_cnt_inc;
        if (!w_level) begin
          w_dbc_nxt   = '0;
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_rise) begin
          w_cand_nxt = r_cnt;
          w_dbc_nxt  = DEB_ONE;
        end else if (w_level) begin
          w_dbc_nxt = r_dbc + DEB_ONE;
        end else begin
          w_dbc_nxt = '0;
        end
        if (w_dbc_nxt == DEB) begin
          w_lag_nxt     = w_cand_nxt;
          w_timeout_nxt = 1'b0;
          w_valid_nxt   = 1'b1;
          w_dbc_nxt     = '0;
          w_state_nxt   = RELEASE;
        end else if (r_cnt == TIMEOUT) begin
          w_lag_nxt     = TIMEOUT;
          w_timeout_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
          w_dbc_nxt     = '0;
          w_state_nxt   = IDLE;
        end
      end
      RELEASE: begin
        // Require a stable dark field before re-arming
        w_dbc_nxt = w_level ? '0 : r_dbc + DEB_ONE;
        if (w_dbc_nxt == DEB) begin
          w_dbc_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign lag_cycles = r_lag_cycles;
  assign lag_valid  = r_lag_valid;
  assign timeout    = r_timeout;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

`ifdef LAG_AVERAGE_EN
  logic [LAG_COUNTER_SIZE-1:0] r_avg_buf [8];
  logic [LAG_COUNTER_SIZE+2:0] r_avg_sum, w_avg_sum_nxt;
  logic [LAG_COUNTER_SIZE-1:0] r_lag_avg;

  // Running sum: add the newest result, drop the one falling out of the window
  always_comb begin
    w_avg_sum_nxt = r_avg_sum + {3'b000, r_lag_cycles} - {3'b000, r_avg_buf[7]};
  end

  // Shift non-timeout results into the window the cycle after the strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_avg_buf[i] <= '0;
      r_avg_sum <= '0;
      r_lag_avg <= '0;
    end else if (r_lag_valid && !r_timeout) begin
      for (int i = 7; i > 0; i--) r_avg_buf[i] <= r_avg_buf[i-1];
      r_avg_buf[0] <= r_lag_cycles;
      r_avg_sum    <= w_avg_sum_nxt;
      r_lag_avg    <= w_avg_sum_nxt[LAG_COUNTER_SIZE+2:3];
    end
  end

  assign lag_avg = r_lag_avg;
`else
  // Averaging disabled: no result window is kept
`endif

endmodule

// File: tb/tb_lag_sensor_capture.sv
// tb/tb_lag_sensor_capture.sv - directed scoreboard bench for lag_sensor_capture
module tb_lag_sensor_capture;

  typedef struct {
    logic [23:0] lag;
    logic        to;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        starttrigger = 1'b0;
  logic        sensor = 1'b0;
  logic [23:0] lag_cycles;
  logic        lag_valid;
  logic        timeout;
  logic        overrun;
  logic        busy;
`ifdef LAG_AVERAGE_EN
  logic [23:0] lag_avg;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  lag_sensor_capture #(
    .SYNC_STAGES     (2),
    .DEBOUNCE        (16),
    .LAG_COUNTER_SIZE(24),
    .TIMEOUT         (24'd5000)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .starttrigger(starttrigger),
    .sensor      (sensor),
    .lag_cycles  (lag_cycles),
    .lag_valid   (lag_valid),
    .timeout     (timeout),
    .overrun     (overrun),
    .busy        (busy)
`ifdef LAG_AVERAGE_EN
    ,
    .lag_avg     (lag_avg)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge; any strobe is matched against the scoreboard
  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (lag_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_valid", {31'd0, lag_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("lag_cycles", {8'd0, lag_cycles}, {8'd0, e.lag});
          check("timeout", {31'd0, timeout}, {31'd0, e.to});
        end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (busy === 1'b0) break;
    end
    check("idle_after_meas", {31'd0, busy}, 32'd0);
  endtask

  // Drive a one-cycle trigger; on return the next input change is sampled at T0+1
  task automatic start_trig(input bit push, input logic [23:0] lag, input logic to);
    exp_t e;
    check("busy_before_trig", {31'd0, busy}, 32'd0);
    if (push) begin
      e.lag = lag;
      e.to  = to;
      q.push_back(e);
    end
    starttrigger = 1'b1;
    tick(1);
    starttrigger = 1'b0;
    check("busy_after_trig", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_lag_cycles", {8'd0, lag_cycles}, 32'd0);
    check("rst_lag_valid", {31'd0, lag_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Light first sampled at T0+1000, held 40 cycles
    start_trig(1, 24'd1001, 1'b0);
    tick(999);
    sensor = 1'b1;
    tick(40);
    sensor = 1'b0;
    wait_idle(200);
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // 5-cycle glitch at T0+300, stable light at T0+800
    start_trig(1, 24'd801, 1'b0);
    tick(299);
    sensor = 1'b1;
    tick(5);
    sensor = 1'b0;
    tick(495);
    sensor = 1'b1;
    tick(40);
    sensor = 1'b0;
    wait_idle(200);

    // Never lit: aborts at the timeout count
    start_trig(1, 24'd5000, 1'b1);
    wait_idle(5200);

    // Light already present at trigger, dark at T0+50, light again at T0+400
    sensor = 1'b1;
    tick(4);
    start_trig(1, 24'd401, 1'b0);
    tick(49);
    sensor = 1'b0;
    tick(350);
    sensor = 1'b1;
    tick(40);
    sensor = 1'b0;
    wait_idle(200);
    check("timeout_cleared", {31'd0, timeout}, 32'd0);

    // Second trigger during MEASURE flags overrun but does not disturb the measurement
    start_trig(1, 24'd601, 1'b0);
    tick(99);
    starttrigger = 1'b1;
    tick(1);
    starttrigger = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    tick(499);
    sensor = 1'b1;
    tick(40);
    sensor = 1'b0;
    wait_idle(200);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

`ifdef LAG_AVERAGE_EN
    // Eight results 100..800 fill the averaging window
    for (int k = 1; k <= 8; k++) begin
      start_trig(1, 24'(100 * k), 1'b0);
      tick(100 * k - 2);
      sensor = 1'b1;
      tick(40);
      sensor = 1'b0;
      wait_idle(200);
    end
    tick(1);
    check("lag_avg", {8'd0, lag_avg}, 32'd450);
`endif

    // Reset mid-MEASURE: outputs clear at once and no strobe follows
    start_trig(0, 24'd0, 1'b0);
    tick(100);
    reset_n = 1'b0;
    #1;
    check("abort_lag_cycles", {8'd0, lag_cycles}, 32'd0);
    check("abort_lag_valid", {31'd0, lag_valid}, 32'd0);
    check("abort_timeout", {31'd0, timeout}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
`ifdef LAG_AVERAGE_EN
    check("abort_lag_avg", {8'd0, lag_avg}, 32'd0);
`endif
    tick(3);
    reset_n = 1'b1;
    tick(50);
    check("busy_after_abort", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
